// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the register file's single write port between two writeback
// requesters (A: execute result, B: load result). After reset an optional
// clear sequence writes zero to x1..x(2^ADDR_W-1); afterwards requests are
// arbitrated round-robin with valid/ready handshakes.
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         synchronous active-low reset
//   a_valid/a_ready/a_addr/a_data   port A request, accept, address, data
//   b_valid/b_ready/b_addr/b_data   port B request, accept, address, data
//   write_address register-file write address (0 = no write)
//   write_data    register-file write data
//   init_done     registered, high once the clear sequence has completed
module regfile_write_arbiter #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              init_done
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic              PRIO_A   = 1'b0;
  localparam logic              PRIO_B   = 1'b1;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] clr_idx_r, clr_idx_s;
  logic              prio_r, prio_s;
  logic              init_done_r, init_done_s;

  logic a_real_s, b_real_s, a_discard_s, b_discard_s;
  logic grant_a_s, grant_b_s;

  // Classify each request and pick the round-robin winner among real ones.
  always_comb begin
    a_real_s    = a_valid && (a_addr != ZERO_IDX);
    b_real_s    = b_valid && (b_addr != ZERO_IDX);
    a_discard_s = a_valid && (a_addr == ZERO_IDX);
    b_discard_s = b_valid && (b_addr == ZERO_IDX);
    grant_a_s   = a_real_s && (!b_real_s || (prio_r == PRIO_A));
    grant_b_s   = b_real_s && (!a_real_s || (prio_r == PRIO_B));
  end

  // Next-state and output decode; everything is forced idle while rst_n is low
  // so an in-flight handshake is dropped during reset cycles.
  always_comb begin
    state_s       = state_r;
    clr_idx_s     = clr_idx_r;
    prio_s        = prio_r;
    init_done_s   = init_done_r;
    a_ready       = 1'b0;
    b_ready       = 1'b0;
    write_address = ZERO_IDX;
    write_data    = {DATA_W{1'b0}};
    if (!rst_n) begin
      state_s = state_r;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          write_address = clr_idx_r;
          // Stop on the last register instead of wrapping back to x0.
          if (clr_idx_r == LAST_IDX) begin
            state_s     = ST_RUN;
            init_done_s = 1'b1;
          end else begin
            clr_idx_s = clr_idx_r + ONE_IDX;
          end
        end
        ST_RUN: begin
          init_done_s = 1'b1;
          // Discards are always accepted but never write or move prio.
          a_ready = a_discard_s || grant_a_s;
          b_ready = b_discard_s || grant_b_s;
          if (grant_a_s) begin
            write_address = a_addr;
            write_data    = a_data;
            prio_s        = PRIO_B;
          end else if (grant_b_s) begin
            write_address = b_addr;
            write_data    = b_data;
            prio_s        = PRIO_A;
          end else begin
            prio_s = prio_r;
          end
        end
        default: begin
          state_s = ST_CLEAR;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_idx_r   <= ONE_IDX;
      prio_r      <= PRIO_A;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      clr_idx_r   <= clr_idx_s;
      prio_r      <= prio_s;
      init_done_r <= init_done_s;
    end
  end

  assign init_done = init_done_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: one instance with the clear
// sequence enabled (driving a small register-file model) and one with it
// disabled.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, a_valid, a_ready, b_valid, b_ready, init_done;
  logic [4:0]  a_addr, b_addr, write_address;
  logic [31:0] a_data, b_data, write_data;

  logic        rst1_n, c_valid, c_ready, z_valid, z_ready, init1;
  logic [4:0]  c_addr, z_addr, wa1;
  logic [31:0] c_data, z_data, wd1;

  logic [31:0] rf [0:31];

  int checks = 0;
  int fails  = 0;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .write_address(write_address), .write_data(write_data), .init_done(init_done)
  );

  regfile_write_arbiter #(.CLEAR_ON_RESET(0)) dut_noclr (
    .clk(clk), .rst_n(rst1_n),
    .a_valid(c_valid), .a_ready(c_ready), .a_addr(c_addr), .a_data(c_data),
    .b_valid(z_valid), .b_ready(z_ready), .b_addr(z_addr), .b_data(z_data),
    .write_address(wa1), .write_data(wd1), .init_done(init1)
  );

  // Register-file model: poisoned during reset, written at the edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) rf[r] <= 32'hA5A5_A5A5;
    end else if (write_address != 5'd0) begin
      rf[write_address] <= write_data;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
    c_valid = 1'b0; c_addr = 5'd0; c_data = 32'd0;
    z_valid = 1'b0; z_addr = 5'd0; z_data = 32'd0;

    repeat (2) @(negedge clk);
    #1;
    check_value("rst_wa", 32'(write_address), 32'd0);
    check_value("rst_ar", 32'(a_ready), 32'd0);
    check_value("rst_br", 32'(b_ready), 32'd0);
    check_value("rst_init", 32'(init_done), 32'd0);

    // Clear sequence with a request from A pending the whole time.
    @(negedge clk);
    rst_n = 1'b1; a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    for (int i = 1; i <= 31; i++) begin
      #1;
      check_value("clr_wa", 32'(write_address), 32'(i));
      check_value("clr_wd", write_data, 32'd0);
      check_value("clr_ar", 32'(a_ready), 32'd0);
      check_value("clr_init", 32'(init_done), 32'd0);
      @(negedge clk);
    end
    #1;
    check_value("clr_done_init", 32'(init_done), 32'd1);
    check_value("first_ar", 32'(a_ready), 32'd1);
    check_value("first_wa", 32'(write_address), 32'd3);
    check_value("first_wd", write_data, 32'h33);
    for (int r = 1; r < 32; r++) check_value("clr_rf", rf[r], 32'd0);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check_value("first_rf3", rf[3], 32'h33);
    check_value("idle_wa", 32'(write_address), 32'd0);

    // Single requests from each side.
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hDEAD_BEEF;
    #1;
    check_value("single_ar", 32'(a_ready), 32'd1);
    check_value("single_wa", 32'(write_address), 32'd7);
    check_value("single_wd", write_data, 32'hDEAD_BEEF);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h1010;
    #1;
    check_value("single_rf7", rf[7], 32'hDEAD_BEEF);
    check_value("single_br", 32'(b_ready), 32'd1);
    check_value("single_wa_b", 32'(write_address), 32'd10);

    // Contention from prio=A: grants alternate A,B,A,B.
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_value("cont_ar", 32'(a_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      check_value("cont_br", 32'(b_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      check_value("cont_wa", 32'(write_address), (k % 2 == 0) ? 32'd3 : 32'd4);
      check_value("cont_wd", write_data, (k % 2 == 0) ? 32'h11 : 32'h22);
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check_value("cont_rf3", rf[3], 32'h11);
    check_value("cont_rf4", rf[4], 32'h22);

    // Move prio to B, then a discard on A with a real B write moves it to A.
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
    #1;
    check_value("pre_ar", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_addr = 5'd0; b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h55;
    #1;
    check_value("disc_ar", 32'(a_ready), 32'd1);
    check_value("disc_br", 32'(b_ready), 32'd1);
    check_value("disc_wa", 32'(write_address), 32'd5);
    check_value("disc_wd", write_data, 32'h55);
    @(negedge clk);
    a_addr = 5'd8; a_data = 32'h88; b_addr = 5'd9; b_data = 32'h99;
    #1;
    check_value("disc_prio_ar", 32'(a_ready), 32'd1);
    check_value("disc_prio_br", 32'(b_ready), 32'd0);
    check_value("disc_prio_wa", 32'(write_address), 32'd8);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check_value("held_br", 32'(b_ready), 32'd1);
    check_value("held_wd", write_data, 32'h99);
    // prio is A now; a double discard must leave it there.
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd0; b_addr = 5'd0;
    #1;
    check_value("dd_ar", 32'(a_ready), 32'd1);
    check_value("dd_br", 32'(b_ready), 32'd1);
    check_value("dd_wa", 32'(write_address), 32'd0);
    check_value("dd_wd", write_data, 32'd0);
    @(negedge clk);
    a_addr = 5'd11; a_data = 32'hAA; b_addr = 5'd12; b_data = 32'hBB;
    #1;
    check_value("dd_prio_ar", 32'(a_ready), 32'd1);
    check_value("dd_prio_br", 32'(b_ready), 32'd0);
    check_value("dd_prio_wa", 32'(write_address), 32'd11);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check_value("rf5", rf[5], 32'h55);
    check_value("rf6", rf[6], 32'h66);
    check_value("rf8", rf[8], 32'h88);
    check_value("rf9", rf[9], 32'h99);
    check_value("rf11", rf[11], 32'hAA);

    // Reset mid-operation, then reset again mid-clear at clr_idx=12.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      #1;
      check_value("re_wa", 32'(write_address), 32'(i));
      @(negedge clk);
    end
    #1;
    check_value("re_wa12", 32'(write_address), 32'd12);
    rst_n = 1'b0; a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h2222;
    #1;
    check_value("inrst_wa", 32'(write_address), 32'd0);
    check_value("inrst_ar", 32'(a_ready), 32'd0);
    check_value("inrst_init", 32'(init_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      #1;
      check_value("re2_wa", 32'(write_address), 32'(i));
      check_value("re2_init", 32'(init_done), 32'd0);
      check_value("re2_ar", 32'(a_ready), 32'd0);
      @(negedge clk);
    end
    #1;
    check_value("re2_done", 32'(init_done), 32'd1);
    check_value("re2_ar_run", 32'(a_ready), 32'd1);
    check_value("re2_wa_run", 32'(write_address), 32'd2);
    @(negedge clk);
    a_valid = 1'b0;

    // Instance without clear sequence.
    c_valid = 1'b1; c_addr = 5'd9; c_data = 32'h99;
    #1;
    check_value("nc_rst_ar", 32'(c_ready), 32'd0);
    check_value("nc_rst_wa", 32'(wa1), 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;
    #1;
    check_value("nc_init0", 32'(init1), 32'd0);
    check_value("nc_ar", 32'(c_ready), 32'd1);
    check_value("nc_wa", 32'(wa1), 32'd9);
    check_value("nc_wd", wd1, 32'h99);
    @(negedge clk);
    c_valid = 1'b0;
    #1;
    check_value("nc_init1", 32'(init1), 32'd1);
    check_value("nc_idle_wa", 32'(wa1), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
